// File: rtl/sar_search8.sv
// sar_search8 - successive-approximation search controller.
//
// Drives the B operand (guess) of an external magnitude comparator and
// narrows a [lo, hi] window from its greater/equal/less outputs until the
// hidden operand A is found, the window is exhausted, or the comparator
// reports a non-one-hot result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new search (only honoured in IDLE)
//   cmp_gt     comparator: target > guess
//   cmp_eq     comparator: target == guess
//   cmp_lt     comparator: target < guess
//   guess      registered comparator B operand
//   busy       high while a search is in progress
//   done       one-cycle pulse at the end of every search
//   found      search ended on equality (held until next start)
//   cmp_error  comparator outputs were not one-hot (held until next start)
//   result     matching value when found, else 0 (held until next start)
//   steps      comparisons made in the last/current search (saturates at 15)

module sar_search8 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CMP_LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             cmp_error,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    localparam logic [3:0]       Lat     = 4'(CMP_LATENCY);
    localparam logic [WIDTH-1:0] MaxVal  = '1;
    localparam logic [WIDTH-1:0] InitMid = MaxVal >> 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] guess_q, lo_q, hi_q, result_q;
    logic [3:0]       wait_q, steps_q;
    logic             found_q, err_q;

    logic             sample, one_hot, finish;
    logic [2:0]       cmp_vec;
    logic [WIDTH:0]   sum_up, sum_dn;
    logic [WIDTH-1:0] mid_up, mid_dn;

    // Decode of the current comparator sample and the candidate next guesses.
    always_comb begin
        cmp_vec = {cmp_gt, cmp_eq, cmp_lt};
        sample  = (state_q == StCompare) && (wait_q == Lat);
        one_hot = (cmp_vec == 3'b100) || (cmp_vec == 3'b010) || (cmp_vec == 3'b001);
        // One extra bit so lo+hi up to 2*(2^WIDTH-1) does not wrap.
        sum_up  = {1'b0, guess_q} + {1'b0, hi_q} + {{WIDTH{1'b0}}, 1'b1};
        sum_dn  = {1'b0, lo_q} + {1'b0, guess_q} - {{WIDTH{1'b0}}, 1'b1};
        mid_up  = WIDTH'(sum_up >> 1);
        mid_dn  = WIDTH'(sum_dn >> 1);
        // Window-edge checks stop the search before lo/hi could wrap.
        finish  = sample && (!one_hot || cmp_eq ||
                             (cmp_gt && (guess_q == hi_q)) ||
                             (cmp_lt && (guess_q == lo_q)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCompare;
            StCompare: if (finish) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q == StCompare);
        done = (state_q == StDone);
    end

    // Search datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guess_q  <= '0;
            lo_q     <= '0;
            hi_q     <= MaxVal;
            result_q <= '0;
            wait_q   <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            guess_q  <= InitMid;
            lo_q     <= '0;
            hi_q     <= MaxVal;
            result_q <= '0;
            wait_q   <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (sample) begin
            wait_q  <= '0;
            steps_q <= (steps_q == 4'hF) ? 4'hF : steps_q + 4'd1;
            if (!one_hot) begin
                err_q   <= 1'b1;
                found_q <= 1'b0;
            end else if (cmp_eq) begin
                found_q  <= 1'b1;
                result_q <= guess_q;
            end else if (cmp_gt) begin
                if (guess_q != hi_q) begin
                    lo_q    <= guess_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    guess_q <= mid_up;
                end
            end else begin
                if (guess_q != lo_q) begin
                    hi_q    <= guess_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    guess_q <= mid_dn;
                end
            end
        end else if (state_q == StCompare) begin
            wait_q <= wait_q + 4'd1;
        end
    end

    assign guess     = guess_q;
    assign found     = found_q;
    assign cmp_error = err_q;
    assign result    = result_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_sar_search8.sv
// tb_sar_search8 - directed, table-driven bench for sar_search8.
// Two instances: combinational comparator (latency 0) and latency 2.
// A behavioural comparator answers from the bench-owned target and mode.

module tb_sar_search8;

    logic clk;
    logic rst_n;
    logic start0, start1;
    logic gt0, eq0, lt0, gt1, eq1, lt1;
    logic [7:0] guess0, guess1, result0, result1;
    logic busy0, busy1, done0, done1, found0, found1, err0, err1;
    logic [3:0] steps0, steps1;

    int unsigned target;
    int unsigned mode;   // 0 normal, 1 always lt, 2 always gt, 3 gt&lt after 1st, 4 none after 1st
    int unsigned sel;

    int total = 0;
    int bad   = 0;

    int unsigned seq [64];
    int unsigned exp200 [8] = '{127, 191, 223, 207, 199, 203, 201, 200};

    sar_search8 #(.WIDTH(8), .CMP_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
        .guess(guess0), .busy(busy0), .done(done0), .found(found0),
        .cmp_error(err0), .result(result0), .steps(steps0)
    );

    sar_search8 #(.WIDTH(8), .CMP_LATENCY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cmp_gt(gt1), .cmp_eq(eq1), .cmp_lt(lt1),
        .guess(guess1), .busy(busy1), .done(done1), .found(found1),
        .cmp_error(err1), .result(result1), .steps(steps1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] cmp_model(int unsigned md, int unsigned tg, logic [7:0] g);
        logic [2:0] r;
        r = {(tg > 32'(g)), (tg == 32'(g)), (tg < 32'(g))};
        case (md)
            1: r = 3'b001;
            2: r = 3'b100;
            3: if (g != 8'd127) r = 3'b101;
            4: if (g != 8'd127) r = 3'b000;
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        {gt0, eq0, lt0} = cmp_model(mode, target, guess0);
        {gt1, eq1, lt1} = cmp_model(mode, target, guess1);
    end

    // Selected-instance view.
    logic [7:0] c_guess, c_result;
    logic c_busy, c_done, c_found, c_err;
    logic [3:0] c_steps;
    always_comb begin
        c_guess  = sel[0] ? guess1  : guess0;
        c_result = sel[0] ? result1 : result0;
        c_busy   = sel[0] ? busy1   : busy0;
        c_done   = sel[0] ? done1   : done0;
        c_found  = sel[0] ? found1  : found0;
        c_err    = sel[0] ? err1    : err0;
        c_steps  = sel[0] ? steps1  : steps0;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel[0]) start1 = v;
        else start0 = v;
    endtask

    typedef struct {
        int unsigned sel;
        int unsigned target;
        int unsigned mode;
        int          restart_at;
        bit          chk_seq;
        bit          exp_found;
        int unsigned exp_result;
        int unsigned exp_steps;
        bit          exp_err;
    } vec_t;

    task automatic run_vec(input string tag, input vec_t v);
        int unsigned lat;
        int n;
        int cycles;
        logic [7:0] g_hold;
        sel    = v.sel;
        target = v.target;
        mode   = v.mode;
        lat    = (v.sel != 0) ? 2 : 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        chk({tag, ".clr_err"}, 32'(c_err), 0);
        chk({tag, ".busy0"}, 32'(c_busy), 1);
        n = 0;
        cycles = 0;
        while (!c_done && cycles < 200) begin
            if (c_busy && n < 64) begin
                seq[n] = 32'(c_guess);
                n++;
            end
            if (cycles == v.restart_at) set_start(1'b1);
            tick();
            set_start(1'b0);
            cycles++;
        end
        if (!c_done) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: got no done want done", tag);
            return;
        end
        chk({tag, ".busy_done"}, 32'(c_busy), 0);
        chk({tag, ".found"}, 32'(c_found), 32'(v.exp_found));
        chk({tag, ".result"}, 32'(c_result), v.exp_result);
        chk({tag, ".steps"}, 32'(c_steps), v.exp_steps);
        chk({tag, ".err"}, 32'(c_err), 32'(v.exp_err));
        chk({tag, ".busy_cycles"}, 32'(n), v.exp_steps * (lat + 1));
        if (v.chk_seq) begin
            for (int i = 0; i < n && i < 24; i++) begin
                chk($sformatf("%s.seq%0d", tag, i), seq[i], exp200[i / (lat + 1)]);
            end
        end
        g_hold = c_guess;
        tick();
        chk({tag, ".done_pulse"}, 32'(c_done), 0);
        chk({tag, ".idle_busy"}, 32'(c_busy), 0);
        chk({tag, ".guess_hold"}, 32'(c_guess), 32'(g_hold));
        chk({tag, ".found_hold"}, 32'(c_found), 32'(v.exp_found));
    endtask

    vec_t vecs [12];

    initial begin
        //          sel tgt  mode rst seq fnd res  stp err
        vecs[0]  = '{0, 200, 0, -1, 1, 1, 200, 8, 0};
        vecs[1]  = '{0, 127, 0, -1, 0, 1, 127, 1, 0};
        vecs[2]  = '{0, 255, 0, -1, 0, 1, 255, 9, 0};
        vecs[3]  = '{0,   0, 0, -1, 0, 1,   0, 8, 0};
        vecs[4]  = '{0,   0, 1, -1, 0, 0,   0, 8, 0};
        vecs[5]  = '{0,   0, 2, -1, 0, 0,   0, 9, 0};
        vecs[6]  = '{0, 200, 3, -1, 0, 0,   0, 2, 1};
        vecs[7]  = '{0, 128, 0, -1, 0, 1, 128, 8, 0};
        vecs[8]  = '{0, 200, 4, -1, 0, 0,   0, 2, 1};
        vecs[9]  = '{0,   1, 0, -1, 0, 1,   1, 7, 0};
        vecs[10] = '{1, 200, 0, -1, 1, 1, 200, 8, 0};
        vecs[11] = '{0, 200, 0,  3, 1, 1, 200, 8, 0};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        sel    = 0;
        target = 0;
        mode   = 0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d.guess", s), 32'(c_guess), 0);
            chk($sformatf("rst%0d.busy", s), 32'(c_busy), 0);
            chk($sformatf("rst%0d.done", s), 32'(c_done), 0);
            chk($sformatf("rst%0d.found", s), 32'(c_found), 0);
            chk($sformatf("rst%0d.err", s), 32'(c_err), 0);
            chk($sformatf("rst%0d.result", s), 32'(c_result), 0);
            chk($sformatf("rst%0d.steps", s), 32'(c_steps), 0);
        end
        sel = 0;
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            tick();
        end

        // Reset during the fourth comparison aborts at once, no done pulse.
        sel    = 0;
        target = 200;
        mode   = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        tick();
        chk("abort.pre_guess", 32'(guess0), 207);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.guess", 32'(guess0), 0);
        chk("abort.busy", 32'(busy0), 0);
        chk("abort.done", 32'(done0), 0);
        chk("abort.steps", 32'(steps0), 0);
        chk("abort.found", 32'(found0), 0);
        tick();
        chk("abort.no_done", 32'(done0), 0);
        chk("abort.idle", 32'(busy0), 0);
        rst_n = 1'b1;
        tick();
        run_vec("after_abort", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
